// File: rtl/buffer_texto.sv
// Line buffer fed by the PS/2 translator: captures characters between the start
// and end keys, drops key-release sequences, and serves the message via a read port.
module buffer_texto #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dato_listo,
   input  logic [7:0]    codigo,
   input  logic          valido,
   input  logic          iniciar,
   input  logic          terminar,
   input  logic [6:0]    traduccion,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [6:0]    rd_data,
   output logic [AW:0]   cuenta,
   output logic          capturando,
   output logic          mensaje_listo,
   output logic          lleno,
   output logic          error_desborde
);

   typedef enum logic [1:0] {INACTIVO, CAPTURA, LISTO} estado_t;

   localparam logic [AW:0] MAXC = (AW+1)'(DEPTH);

   estado_t     estado;
   logic        brk;
   logic        aceptado;
   logic        escribe;
   logic [6:0]  mem [DEPTH];

   // An event reaches the FSM only if it is not part of an F0/E0 prefix sequence.
   always_comb begin
      aceptado = dato_listo && (codigo != 8'hF0) && !brk && (codigo != 8'hE0);
      escribe  = aceptado && (estado == CAPTURA) && !terminar && !iniciar &&
                 valido && (cuenta < MAXC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado         <= INACTIVO;
         cuenta         <= '0;
         brk            <= 1'b0;
         error_desborde <= 1'b0;
      end else begin
         if (dato_listo) begin
            if (codigo == 8'hF0)
               brk <= 1'b1;
            else if (brk)
               brk <= 1'b0;
         end
         if (aceptado) begin
            case (estado)
               INACTIVO, LISTO: begin
                  if (!terminar && iniciar) begin
                     estado         <= CAPTURA;
                     cuenta         <= '0;
                     error_desborde <= 1'b0;
                  end
               end
               CAPTURA: begin
                  if (terminar) begin
                     estado <= LISTO;
                  end else if (iniciar) begin
                     cuenta         <= '0;
                     error_desborde <= 1'b0;
                  end else if (valido) begin
                     if (cuenta < MAXC)
                        cuenta <= cuenta + 1'b1;
                     else
                        error_desborde <= 1'b1;
                  end
               end
               default: estado <= INACTIVO;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (escribe)
         mem[cuenta[AW-1:0]] <= traduccion;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= ({1'b0, rd_addr} < cuenta) ? mem[rd_addr] : 7'h00;
   end

   always_comb begin
      capturando    = (estado == CAPTURA);
      mensaje_listo = (estado == LISTO);
      lleno         = (cuenta == MAXC);
   end

endmodule

// File: tb/tb_buffer_texto.sv
// Directed bench for buffer_texto; read results are checked through a scoreboard queue.
module tb_buffer_texto;

   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          dato_listo = 1'b0;
   logic [7:0]    codigo = '0;
   logic          valido = 1'b0;
   logic          iniciar = 1'b0;
   logic          terminar = 1'b0;
   logic [6:0]    traduccion = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [6:0]    rd_data;
   logic [AW:0]   cuenta;
   logic          capturando;
   logic          mensaje_listo;
   logic          lleno;
   logic          error_desborde;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [6:0]  exp_q [$];

   buffer_texto #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .dato_listo(dato_listo), .codigo(codigo),
      .valido(valido), .iniciar(iniciar), .terminar(terminar),
      .traduccion(traduccion), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .cuenta(cuenta), .capturando(capturando),
      .mensaje_listo(mensaje_listo), .lleno(lleno),
      .error_desborde(error_desborde)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One event: inputs held for exactly one rising edge, driven from the falling edge.
   task automatic ev(input logic [7:0] c, input logic v, input logic ini,
                     input logic ter, input logic [6:0] t);
      @(negedge clk);
      dato_listo = 1'b1; codigo = c; valido = v; iniciar = ini; terminar = ter; traduccion = t;
      @(negedge clk);
      dato_listo = 1'b0; codigo = '0; valido = 1'b0; iniciar = 1'b0; terminar = 1'b0;
   endtask

   task automatic start();    ev(8'h5A, 1'b0, 1'b1, 1'b0, 7'h00); endtask
   task automatic stop();     ev(8'h66, 1'b0, 1'b0, 1'b1, 7'h00); endtask
   task automatic chr(input logic [7:0] c, input logic [6:0] t); ev(c, 1'b1, 1'b0, 1'b0, t); endtask

   task automatic rd(input string tag, input logic [AW-1:0] a, input logic [6:0] exp);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = a;
      exp_q.push_back(exp);
      @(negedge clk);
      rd_en = 1'b0;
      chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_cuenta", 32'(cuenta), 32'd0);
      chk("reset_flags", {capturando, mensaje_listo, lleno, error_desborde}, 4'b0000);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      reset = 1'b1;

      // Basic message
      start();
      chk("t2_capturando", 32'(capturando), 32'd1);
      chr(8'h33, 7'h48);
      chr(8'h43, 7'h49);
      stop();
      chk("t2_cuenta", 32'(cuenta), 32'd2);
      chk("t2_listo", {capturando, mensaje_listo}, 2'b01);
      rd("t2_addr0", 5'd0, 7'h48);
      rd("t2_addr1", 5'd1, 7'h49);
      rd("t2_addr2", 5'd2, 7'h00);

      // Events ignored in LISTO
      chr(8'h35, 7'h59);
      chk("t5_listo_ignore_cuenta", 32'(cuenta), 32'd2);
      chk("t5_listo_ignore_state", 32'(mensaje_listo), 32'd1);
      rd("t5_listo_addr2", 5'd2, 7'h00);

      // Prefix filtering
      start();
      chk("t3_restart_cuenta", 32'(cuenta), 32'd0);
      chr(8'h1C, 7'h41);
      ev(8'hF0, 1'b0, 1'b0, 1'b0, 7'h00);
      chr(8'h1C, 7'h41);
      chk("t3_break_cuenta", 32'(cuenta), 32'd1);
      ev(8'hF0, 1'b0, 1'b0, 1'b0, 7'h00);
      stop();
      chk("t3_break_terminar_ignored", 32'(capturando), 32'd1);
      ev(8'hE0, 1'b0, 1'b0, 1'b0, 7'h00);
      chr(8'h32, 7'h42);
      chk("t3_e0_cuenta", 32'(cuenta), 32'd2);
      rd("t3_addr0", 5'd0, 7'h41);
      rd("t3_addr1", 5'd1, 7'h42);

      // Asynchronous reset mid-capture, checked between clock edges
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t1_async_cuenta", 32'(cuenta), 32'd0);
      chk("t1_async_flags", {capturando, mensaje_listo, lleno, error_desborde}, 4'b0000);
      chk("t1_async_rd_data", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("t1_after_release", {capturando, mensaje_listo}, 2'b00);

      // Events without a preceding start key
      stop();
      chr(8'h22, 7'h58);
      chk("t5_inactivo_cuenta", 32'(cuenta), 32'd0);
      chk("t5_inactivo_state", {capturando, mensaje_listo}, 2'b00);

      // Overflow
      start();
      for (int i = 0; i < 33; i++) chr(8'h2C, 7'(32'h20 + i));
      chk("t4_cuenta", 32'(cuenta), 32'd32);
      chk("t4_lleno", 32'(lleno), 32'd1);
      chk("t4_error", 32'(error_desborde), 32'd1);
      rd("t4_addr0", 5'd0, 7'h20);
      rd("t4_addr31", 5'd31, 7'h3F);

      // Simultaneous start+end keys: end wins
      ev(8'h5A, 1'b0, 1'b1, 1'b1, 7'h00);
      chk("t6_listo", {capturando, mensaje_listo}, 2'b01);
      chk("t6_frozen_cuenta", 32'(cuenta), 32'd32);
      start();
      chk("t6_restart_state", {capturando, mensaje_listo}, 2'b10);
      chk("t6_restart_cuenta", 32'(cuenta), 32'd0);
      chk("t6_restart_flags", {lleno, error_desborde}, 2'b00);
      rd("t6_addr0_empty", 5'd0, 7'h00);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
